// File: rtl/operand_load.sv
// Operand-fetch stage: one independent lane per issue port. Each lane resolves
// its source operands (immediate, zero-cycle forward, writeback bypass or
// register file), holds the uop while operands are pending or the consumer
// stalls, and presents it with a one-hot execution-unit enable.
module operand_load #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned NUM_OPS   = 2,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned TAG_W     = 7,
  parameter int unsigned SQN_W     = 7,
  parameter int unsigned NUM_WBS   = 4,
  parameter int unsigned NUM_ZC    = 2,
  parameter int unsigned NUM_XUS   = 8,
  parameter int unsigned PAY_W     = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_LANES-1:0]                 IN_uopValid,
  output logic [NUM_LANES-1:0]                 OUT_ready,
  input  logic [NUM_LANES*SQN_W-1:0]           IN_uopSqN,
  input  logic [NUM_LANES*NUM_OPS*TAG_W-1:0]   IN_uopTag,
  input  logic [NUM_LANES*NUM_OPS-1:0]         IN_uopPend,
  input  logic [NUM_LANES*XLEN-1:0]            IN_uopImm,
  input  logic [NUM_LANES-1:0]                 IN_uopImmB,
  input  logic [NUM_LANES*4-1:0]               IN_uopFU,
  input  logic [NUM_LANES*PAY_W-1:0]           IN_uopPayload,
  output logic [NUM_LANES*NUM_OPS*(TAG_W-1)-1:0] OUT_rfReadAddr,
  input  logic [NUM_LANES*NUM_OPS*XLEN-1:0]    IN_rfReadData,
  input  logic [NUM_WBS-1:0]                   IN_wbValid,
  input  logic [NUM_WBS*TAG_W-1:0]             IN_wbTag,
  input  logic [NUM_WBS*XLEN-1:0]              IN_wbResult,
  input  logic [NUM_ZC-1:0]                    IN_zcValid,
  input  logic [NUM_ZC*TAG_W-1:0]              IN_zcTag,
  input  logic [NUM_ZC*XLEN-1:0]               IN_zcResult,
  input  logic                                 IN_invalidate,
  input  logic [SQN_W-1:0]                     IN_invalidateSqN,
  input  logic [NUM_LANES-1:0]                 IN_stall,
  output logic [NUM_LANES-1:0]                 OUT_uopValid,
  output logic [NUM_LANES*NUM_OPS*XLEN-1:0]    OUT_operands,
  output logic [NUM_LANES*SQN_W-1:0]           OUT_sqN,
  output logic [NUM_LANES*4-1:0]               OUT_funcUnit,
  output logic [NUM_LANES*PAY_W-1:0]           OUT_payload,
  output logic [NUM_LANES*NUM_XUS-1:0]         OUT_enableXU
);

  // Sequence number s lies after the flush boundary (wrap-around compare).
  function automatic logic younger(input logic [SQN_W-1:0] s,
                                   input logic inv,
                                   input logic [SQN_W-1:0] bnd);
    logic [SQN_W-1:0] diff;
    diff = s - bnd;
    return inv && !diff[SQN_W-1] && (diff != '0);
  endfunction

  // Bus snoop: returns {hit, value}. Later loop iterations override earlier
  // ones, so the highest bus index wins and any ZC match beats any WB match.
  function automatic logic [XLEN:0] snoop(
    input logic [TAG_W-1:0]        tag,
    input logic [NUM_WBS-1:0]      wbv,
    input logic [NUM_WBS*TAG_W-1:0] wbt,
    input logic [NUM_WBS*XLEN-1:0] wbr,
    input logic [NUM_ZC-1:0]       zcv,
    input logic [NUM_ZC*TAG_W-1:0] zct,
    input logic [NUM_ZC*XLEN-1:0]  zcr);
    logic [XLEN:0] res;
    res = '0;
    for (int unsigned w = 0; w < NUM_WBS; w++)
      if (wbv[w] && (wbt[w*TAG_W +: TAG_W] == tag)) res = {1'b1, wbr[w*XLEN +: XLEN]};
    for (int unsigned z = 0; z < NUM_ZC; z++)
      if (zcv[z] && (zct[z*TAG_W +: TAG_W] == tag)) res = {1'b1, zcr[z*XLEN +: XLEN]};
    return res;
  endfunction

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic               valid_q;
    logic [SQN_W-1:0]   sqn_q;
    logic [3:0]         fu_q;
    logic [PAY_W-1:0]   pay_q;
    logic [NUM_OPS-1:0] rdy;
    logic               all_ready, out_valid, ready, accept, flush, consume;

    assign all_ready = &rdy;
    assign out_valid = valid_q && all_ready;
    assign ready     = !valid_q || (all_ready && !IN_stall[l]);
    assign accept    = IN_uopValid[l] && ready &&
                       !younger(IN_uopSqN[l*SQN_W +: SQN_W], IN_invalidate, IN_invalidateSqN);
    assign flush     = younger(sqn_q, IN_invalidate, IN_invalidateSqN);
    assign consume   = out_valid && !IN_stall[l];

    assign OUT_ready[l]                 = ready;
    assign OUT_uopValid[l]              = out_valid;
    assign OUT_sqN[l*SQN_W +: SQN_W]    = sqn_q;
    assign OUT_funcUnit[l*4 +: 4]       = fu_q;
    assign OUT_payload[l*PAY_W +: PAY_W] = pay_q;
    // Shifting past the top bit leaves zero, so out-of-range FUs enable nothing.
    assign OUT_enableXU[l*NUM_XUS +: NUM_XUS] = out_valid ? (NUM_XUS'(1) << fu_q) : '0;

    // Lane valid and uop fields: flush and drain only act when no new uop lands.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        fu_q    <= '0;
      end else if (accept) begin
        valid_q <= 1'b1;
        sqn_q   <= IN_uopSqN[l*SQN_W +: SQN_W];
        fu_q    <= IN_uopFU[l*4 +: 4];
        pay_q   <= IN_uopPayload[l*PAY_W +: PAY_W];
      end else if (valid_q && (flush || consume)) begin
        valid_q <= 1'b0;
      end
    end

    for (genvar k = 0; k < NUM_OPS; k++) begin : g_op
      localparam int unsigned IDX = l*NUM_OPS + k;
      logic [TAG_W-1:0] tag, tag_q;
      logic [XLEN-1:0]  op_q, cap_val;
      logic             rdy_q, cap_rdy;
      logic [XLEN:0]    snp_new, snp_held;

      assign tag      = IN_uopTag[IDX*TAG_W +: TAG_W];
      assign snp_new  = snoop(tag, IN_wbValid, IN_wbTag, IN_wbResult,
                              IN_zcValid, IN_zcTag, IN_zcResult);
      assign snp_held = snoop(tag_q, IN_wbValid, IN_wbTag, IN_wbResult,
                              IN_zcValid, IN_zcTag, IN_zcResult);
      assign rdy[k]   = rdy_q;
      assign OUT_rfReadAddr[IDX*(TAG_W-1) +: TAG_W-1] = tag[TAG_W-2:0];
      assign OUT_operands[IDX*XLEN +: XLEN]           = op_q;

      // Operand source selection at issue time.
      always_comb begin
        cap_val = IN_rfReadData[IDX*XLEN +: XLEN];
        cap_rdy = !IN_uopPend[IDX];
        if ((k == 1) && IN_uopImmB[l]) begin
          cap_val = IN_uopImm[l*XLEN +: XLEN];
          cap_rdy = 1'b1;
        end else if (tag[TAG_W-1]) begin
          cap_val = {{(XLEN-TAG_W+1){tag[TAG_W-2]}}, tag[TAG_W-2:0]};
          cap_rdy = 1'b1;
        end else if (snp_new[XLEN]) begin
          cap_val = snp_new[XLEN-1:0];
          cap_rdy = 1'b1;
        end
      end

      // Operand register: capture on accept, otherwise fill a pending operand from the buses.
      always_ff @(posedge clk) begin
        if (rst) begin
          rdy_q <= 1'b0;
        end else if (accept) begin
          rdy_q <= cap_rdy;
          op_q  <= cap_val;
          tag_q <= tag;
        end else if (valid_q && !rdy_q && snp_held[XLEN]) begin
          rdy_q <= 1'b1;
          op_q  <= snp_held[XLEN-1:0];
        end
      end
    end
  end

endmodule
